// File: rtl/arr2x2_ctrl_pkg.sv
// Shared definitions for the 2x2 array controller.
// Contents: schedule state enum, operand/accumulator widths, default array
// latency and the width of the in-job cycle counter.
package arr_pkg;

    localparam int DATA_W        = 8;
    localparam int ACC_W         = 24;
    localparam int LAT_C_DEFAULT = 2;
    // Counter must reach LAT_C+2 for LAT_C up to 15.
    localparam int CNT_W         = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADW0,
        S_LOADW1,
        S_FEED0,
        S_FEED1,
        S_FEED2,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/arr2x2_ctrl_if.sv
// Job-side interface of the 2x2 array controller.
// master: job requester (drives start/keep_w/operands, reads busy/done/results)
// slave : controller
// Optional macro ARR_CTRL_FAULT_EN adds the fault-injection requests
// inj_mac / inj_mult, latched by the controller together with start.
interface arr2x2_ctrl_if;
    import arr_pkg::*;

    logic              start;
    logic              keep_w;
    logic [DATA_W-1:0] w00, w01, w10, w11;
    logic [DATA_W-1:0] a00, a01, a10, a11;
    logic              busy;
    logic              done;
    logic [ACC_W-1:0]  r00, r01, r10, r11;

`ifdef ARR_CTRL_FAULT_EN
    logic              inj_mac;
    logic              inj_mult;

    modport master (
        output start, keep_w, w00, w01, w10, w11, a00, a01, a10, a11,
               inj_mac, inj_mult,
        input  busy, done, r00, r01, r10, r11
    );
    modport slave (
        input  start, keep_w, w00, w01, w10, w11, a00, a01, a10, a11,
               inj_mac, inj_mult,
        output busy, done, r00, r01, r10, r11
    );
`else
    modport master (
        output start, keep_w, w00, w01, w10, w11, a00, a01, a10, a11,
        input  busy, done, r00, r01, r10, r11
    );
    modport slave (
        input  start, keep_w, w00, w01, w10, w11, a00, a01, a10, a11,
        output busy, done, r00, r01, r10, r11
    );
`endif

endinterface

// File: rtl/arr2x2_ctrl.sv
// Controller for a 2x2 weight-stationary systolic array.
// Loads the weight matrix in two beats (unless reusing valid weights), feeds
// the activation matrix in a skewed three-beat pattern, captures the four
// results from the array outputs at fixed latencies and pulses done.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   job (slave)          start/keep_w/operands in, busy/done/r00..r11 out
//   w1_in, w2_in         weight drives (non-zero only while loading)
//   a1_in, a2_in         skewed activation drives
//   hold                 array weight hold
//   Err_mac, Err_mult    array fault controls
//   c1_out, c2_out       array result columns
// Parameter LAT_C: cycles from first activation beat to first valid c1_out (>=1).
// Optional macro ARR_CTRL_FAULT_EN: Err_* follow the fault requests latched
// with start while the array is fed/drained; otherwise Err_* are tied low.
module arr2x2_ctrl
    import arr_pkg::*;
#(
    parameter int LAT_C = LAT_C_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    arr2x2_ctrl_if.slave      job,
    output logic [DATA_W-1:0] w1_in,
    output logic [DATA_W-1:0] w2_in,
    output logic [DATA_W-1:0] a1_in,
    output logic [DATA_W-1:0] a2_in,
    output logic              hold,
    output logic              Err_mac,
    output logic              Err_mult,
    input  logic [ACC_W-1:0]  c1_out,
    input  logic [ACC_W-1:0]  c2_out
);

    localparam logic [CNT_W-1:0] T_R00  = CNT_W'(LAT_C);
    localparam logic [CNT_W-1:0] T_MID  = CNT_W'(LAT_C + 1);
    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(LAT_C + 2);

    state_t                       state_reg, state_next;
    logic [CNT_W-1:0]             t_reg;
    logic                         wvalid_reg;
    logic                         hold_reg;
    logic [ACC_W-1:0]             r00_reg, r01_reg, r10_reg, r11_reg;
    logic [3:0][DATA_W-1:0]       w_reg, a_reg;
    logic [3:0][DATA_W-1:0]       w_vec, a_vec;
    logic                         accept;
    logic                         running;

    // Element order 0..3 = 00, 01, 10, 11.
    assign w_vec   = {job.w11, job.w10, job.w01, job.w00};
    assign a_vec   = {job.a11, job.a10, job.a01, job.a00};
    assign accept  = (state_reg == S_IDLE) && job.start;
    assign running = state_reg inside {S_FEED0, S_FEED1, S_FEED2, S_DRAIN};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_operand
            always_ff @(posedge clk) begin
                if (rst) begin
                    w_reg[gi] <= '0;
                    a_reg[gi] <= '0;
                end else if (accept) begin
                    w_reg[gi] <= w_vec[gi];
                    a_reg[gi] <= a_vec[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        w1_in      = '0;
        w2_in      = '0;
        a1_in      = '0;
        a2_in      = '0;
        case (state_reg)
            S_IDLE: begin
                if (job.start) begin
                    state_next = (job.keep_w && wvalid_reg) ? S_FEED0 : S_LOADW0;
                end
            end
            S_LOADW0: begin
                w1_in      = w_reg[0];
                w2_in      = w_reg[1];
                state_next = S_LOADW1;
            end
            S_LOADW1: begin
                w1_in      = w_reg[2];
                w2_in      = w_reg[3];
                state_next = S_FEED0;
            end
            S_FEED0: begin
                a1_in      = a_reg[0];
                state_next = S_FEED1;
            end
            S_FEED1: begin
                a1_in      = a_reg[2];
                a2_in      = a_reg[1];
                state_next = S_FEED2;
            end
            S_FEED2: begin
                a2_in      = a_reg[3];
                state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (t_reg == T_LAST) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            t_reg      <= '0;
            wvalid_reg <= 1'b0;
            hold_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            // t is zero on entry to FEED0 because it idles at zero elsewhere.
            t_reg     <= running ? t_reg + 1'b1 : '0;
            if (state_reg == S_LOADW1) begin
                wvalid_reg <= 1'b1;
            end
            // hold drops for the load beats and is kept high afterwards,
            // including the idle time between jobs.
            if (state_next inside {S_LOADW0, S_LOADW1}) begin
                hold_reg <= 1'b0;
            end else if (state_next == S_FEED0) begin
                hold_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r00_reg <= '0;
            r01_reg <= '0;
            r10_reg <= '0;
            r11_reg <= '0;
        end else if (running) begin
            if (t_reg == T_R00) begin
                r00_reg <= c1_out;
            end
            if (t_reg == T_MID) begin
                r10_reg <= c1_out;
                r01_reg <= c2_out;
            end
            if (t_reg == T_LAST) begin
                r11_reg <= c2_out;
            end
        end
    end

`ifdef ARR_CTRL_FAULT_EN
    logic inj_mac_reg, inj_mult_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            inj_mac_reg  <= 1'b0;
            inj_mult_reg <= 1'b0;
        end else if (accept) begin
            inj_mac_reg  <= job.inj_mac;
            inj_mult_reg <= job.inj_mult;
        end
    end

    assign Err_mac  = running & inj_mac_reg;
    assign Err_mult = running & inj_mult_reg;
`else
    assign Err_mac  = 1'b0;
    assign Err_mult = 1'b0;
`endif

    assign hold     = hold_reg;
    assign job.busy = (state_reg != S_IDLE);
    assign job.done = (state_reg == S_DONE);
    assign job.r00  = r00_reg;
    assign job.r01  = r01_reg;
    assign job.r10  = r10_reg;
    assign job.r11  = r11_reg;

endmodule
